// File: rtl/maze_walker_param.sv
// maze_walker_param: streams in a SIZE x SIZE maze, then walks a
// left/right-hand wall follower from (0,0) to (SIZE-1,SIZE-1).
module maze_walker_param #(
    parameter int SIZE      = 17,
    parameter int MAX_STEPS = 1023,
    parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in,
    input  logic              hand,
    output logic              out_valid,
    output logic [1:0]        out,
    output logic              done,
    output logic              fail,
    output logic [STEP_W-1:0] steps
);
    localparam int CW = $clog2(SIZE);
    localparam int NC = SIZE * SIZE;
    localparam int IW = $clog2(NC);
    localparam logic [CW-1:0]     LAST        = CW'(SIZE - 1);
    localparam logic [STEP_W-1:0] BUDGET_LAST = STEP_W'(MAX_STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WALK} state_t;
    state_t r_state, w_next;

    logic [1:0]        r_maze [2**IW];
    logic [IW-1:0]     r_cnt;
    logic [CW-1:0]     r_x, r_y;
    logic [1:0]        r_head;
    logic              r_hand, r_sword, r_done, r_fail;
    logic [STEP_W-1:0] r_steps;

    logic          w_beat, w_last_beat, w_sword, w_goal, w_budget;
    logic [IW-1:0] w_cur;
    logic [IW-1:0] w_nidx [4];
    logic [3:0]    w_oob, w_blk;
    logic [1:0]    w_c1, w_c2, w_c3, w_move;
    logic [CW-1:0] w_nx, w_ny;

    assign w_beat      = in_valid && (r_state != S_WALK);
    assign w_last_beat = in_valid && (r_state == S_LOAD)
                         && (r_cnt == IW'(NC - 1));

    assign w_cur     = IW'(int'(r_y) * SIZE + int'(r_x));
    assign w_nidx[0] = w_cur + IW'(1);
    assign w_nidx[1] = w_cur + IW'(SIZE);
    assign w_nidx[2] = w_cur - IW'(1);
    assign w_nidx[3] = w_cur - IW'(SIZE);

    // bit d is set when the neighbour in direction d lies off the grid
    assign w_oob   = {r_y == '0, r_x == '0, r_y == LAST, r_x == LAST};
    assign w_sword = r_sword || (r_maze[w_cur] == 2'd2);

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            w_blk[d] = w_oob[d]
                       || (r_maze[w_nidx[d]] == 2'd1)
                       || ((r_maze[w_nidx[d]] == 2'd3) && !w_sword);
        end
    end

    assign w_c1 = r_hand ? r_head + 2'd1 : r_head + 2'd3;
    assign w_c2 = r_head;
    assign w_c3 = r_hand ? r_head + 2'd3 : r_head + 2'd1;

    always_comb begin
        w_move = r_head + 2'd2;
        if (!w_blk[w_c1])
            w_move = w_c1;
        else if (!w_blk[w_c2])
            w_move = w_c2;
        else if (!w_blk[w_c3])
            w_move = w_c3;
    end

    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        unique case (w_move)
            2'd0: w_nx = r_x + CW'(1);
            2'd1: w_ny = r_y + CW'(1);
            2'd2: w_nx = r_x - CW'(1);
            2'd3: w_ny = r_y - CW'(1);
        endcase
    end

    assign w_goal   = (w_nx == LAST) && (w_ny == LAST);
    assign w_budget = (r_steps == BUDGET_LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = S_LOAD;
            S_LOAD:  if (w_last_beat) w_next = S_WALK;
            S_WALK:  if (w_goal || w_budget) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_head  <= 2'd0;
            r_hand  <= 1'b0;
            r_sword <= 1'b0;
            r_steps <= '0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            if (r_state == S_IDLE && in_valid) begin
                r_cnt   <= IW'(1);
                r_steps <= '0;
                r_sword <= 1'b0;
                r_hand  <= hand;
                r_x     <= '0;
                r_y     <= '0;
                r_head  <= 2'd0;
            end else if (r_state == S_LOAD && in_valid) begin
                r_cnt <= r_cnt + IW'(1);
            end else if (r_state == S_WALK) begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_head  <= w_move;
                r_steps <= r_steps + STEP_W'(1);
                if (r_maze[w_cur] == 2'd2)
                    r_sword <= 1'b1;
                r_done  <= w_goal;
                r_fail  <= w_budget && !w_goal;
            end
        end
    end

    // maze storage needs no reset: every cell is rewritten by each load
    always_ff @(posedge clk) begin
        if (w_beat)
            r_maze[(r_state == S_IDLE) ? '0 : r_cnt] <= in;
    end

    assign out_valid = (r_state == S_WALK);
    assign out       = out_valid ? w_move : 2'd0;
    assign done      = r_done;
    assign fail      = r_fail;
    assign steps     = r_steps;
endmodule

// File: doc/maze_walker_param.md
# maze_walker_param

Parametrised successor of the 17x17 maze walker. It loads a SIZE x SIZE maze streamed one 2-bit cell per cycle, then walks a wall-follower from (0,0) to (SIZE-1,SIZE-1), emitting one move per cycle. New in this generation: run-time left/right-hand rule selection, a step budget with failure reporting, and done/steps status for the downstream scorer.

## Interface
- SIZE, 17: maze edge length, 3..31. Coordinates are $clog2(SIZE) bits wide.
- MAX_STEPS, 1023: move budget per maze, at least 1.
- STEP_W, $clog2(MAX_STEPS+1): width of the steps output.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  cell beat strobe. Asserted for exactly SIZE*SIZE contiguous cycles, only while the block is IDLE.
- in  in  2  cell code: 0 road, 1 wall, 2 sword, 3 monster.
- hand  in  1  rule select, sampled on the first in_valid beat: 0 left-hand, 1 right-hand.
- out_valid  out  1  high while a move is presented.
- out  out  2  move code: 0 RIGHT, 1 DOWN, 2 LEFT, 3 UP. Forced to 0 when out_valid is low.
- done  out  1  one-cycle pulse when the goal is reached.
- fail  out  1  one-cycle pulse when the budget is exhausted.
- steps  out  STEP_W  moves emitted for the last maze. Held until the next load starts.

## Operation
- FSM states:
  - IDLE → LOAD on in_valid.
  - LOAD → WALK after beat SIZE*SIZE is accepted.
  - WALK → IDLE on goal or budget exhaustion.
- Load order is row-major with x fastest: beat k writes cell (k mod SIZE, k div SIZE).
- The first beat is accepted in IDLE. It clears steps and the sword flag and latches hand.
- Cells (0,0) and the goal are guaranteed road.
- Walk start: position (0,0), heading RIGHT, steps = 0.
- A neighbour is blocked when any of these holds:
  - it is out of bounds;
  - its code is 1;
  - its code is 3 and no sword is held.
- Sword held means the flag is set, or the current cell is code 2. The flag sets on the edge leaving a code-2 cell.
- Cells are never modified: swords are not consumed and monsters are not removed.
- Move priority is relative to heading h:
  - left-hand: (h+3) mod 4, h, (h+1) mod 4, then back.
  - right-hand: (h+1) mod 4, h, (h+3) mod 4, then back.
  - Back is always taken if reached, even when it is a wall. A legal maze never leaves the walker fully enclosed.
- Each WALK cycle:
  - out = the chosen move, computed only from registered position, heading, sword flag and maze contents;
  - on the edge, position and heading update to that move and steps increments.
- Goal: if the move taken enters (SIZE-1,SIZE-1), the FSM returns to IDLE and done pulses in the next cycle.
- Budget: if move MAX_STEPS is taken without entering the goal, the FSM returns to IDLE and fail pulses in the next cycle. When the final budgeted move enters the goal, done is reported and fail is not.
- Coordinate arithmetic never wraps, because out-of-bounds neighbours are always blocked.
- in_valid outside IDLE/LOAD is ignored.

## Timing
- Reset values: out_valid 0, out 0, done 0, fail 0, steps 0, FSM in IDLE. Reset is asynchronous: all outputs drop within the cycle rst rises, including mid-LOAD or mid-WALK.
- out_valid rises in the cycle immediately after the last in_valid beat. Moves then stream one per cycle with no gaps.
- out_valid falls in the same cycle that done or fail pulses. steps is already final in that cycle.
- A new load may begin the cycle after done or fail.
- Total WALK cycles = steps.

## Test plan
- Left-hand, SIZE=5, all road -> out 0,0,0,0,1,1,1,1; done pulse; steps=8.
- Right-hand, same maze -> out 1,1,1,1,0,0,0,0; done; steps=8.
- Left-hand, SIZE=3, rows [0 0 0][1 1 3][0 0 0], MAX_STEPS=10 -> out 0,0,2,2,0,0,2,2,0,0; fail pulse, done stays 0; steps=10.
- Left-hand, SIZE=3, rows [0 0 2][1 1 3][0 0 0] -> out 0,0,1,1; done; steps=4. The monster at (2,1) is passable once the sword is held.
- Assert rst for 1 cycle mid-WALK -> out_valid/out/steps are 0 in that cycle. A fresh 5x5 all-road load then produces the first scenario's result.
- Back-to-back runs: first maze left-hand, second loaded the cycle after done with hand=1 -> each run matches its standalone result, and steps resets on the second load's first beat.
